// File: rtl/gf2_mul_serial.sv
// Digit-serial carry-less multiplier over GF(2)[x], DIGIT bits of b per cycle, MSB-first,
// with an optional reduction pass modulo {1, POLY}.
module gf2_mul_serial #(
    parameter int unsigned       WIDTH = 16,
    parameter int unsigned       DIGIT = 4,
    parameter logic [WIDTH-1:0]  POLY  = 16'h100B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-2:0] y
);

    localparam int unsigned AW   = 2 * WIDTH - 1;
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned R    = (WIDTH - 1 + DIGIT - 1) / DIGIT;
    localparam int unsigned CMAX = (N > R) ? N : R;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int          TOP  = 2 * int'(WIDTH) - 2;
    localparam int          DI   = int'(DIGIT);
    localparam int          WI   = int'(WIDTH);
    localparam logic [AW-1:0] PF = AW'({1'b1, POLY});

    typedef enum logic [1:0] {StIdle, StBusy, StReduce, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              mode_q, mode_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [AW-1:0]     y_q, y_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     pp;
    int                top;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (in_valid) state_d = StBusy;
            StBusy:   if (cnt_q == CW'(N - 1)) state_d = mode_q ? StReduce : StDone;
            StReduce: if (cnt_q == CW'(R - 1)) state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        pp     = '0;
        top    = TOP;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    mode_d = mode;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            StBusy: begin
                // Current digit sits in the top DIGIT bits of b_q; b_q shifts left each cycle.
                for (int j = 0; j < DI; j++) begin
                    if (b_q[WI - DI + j]) pp = pp ^ (AW'(a_q) << j);
                end
                acc_d = (acc_q << DIGIT) ^ pp;
                b_d   = b_q << DIGIT;
                cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + 1'b1;
            end
            StReduce: begin
                // Window of DIGIT positions below top, clamped at WIDTH; later positions see
                // the effect of earlier folds in the same cycle.
                top = TOP - int'(cnt_q) * DI;
                for (int k = TOP; k >= WI; k--) begin
                    if (k <= top && k > top - DI && acc_d[k]) begin
                        acc_d = acc_d ^ (PF << (k - WI));
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        y_d = y_q;
        if (state_d == StDone && state_q != StDone) y_d = acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            y_q    <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
        end
    end

    // Outputs depend only on registered state
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        y         = y_q;
    end

endmodule

// File: tb/tb_gf2_mul_serial.sv
// Self-checking bench for gf2_mul_serial: vector table, corner sequences and random stream,
// all checked through an expected-result queue against a bit-level carry-less model.
module tb_gf2_mul_serial;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AW = 2 * W - 1;
    localparam int N  = W / D;
    localparam int R  = (W - 1 + D - 1) / D;
    localparam logic [W-1:0] POLY = 16'h100B;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] y;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [AW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]  va;
        logic [W-1:0]  vb;
        logic          vm;
        logic [AW-1:0] vy;
    } vec_t;

    gf2_mul_serial #(
        .WIDTH(W),
        .DIGIT(D),
        .POLY (POLY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] z,
                                            input logic m);
        logic [AW-1:0] p;
        logic [AW-1:0] pf;
        p  = '0;
        pf = AW'({1'b1, POLY});
        for (int i = 0; i < W; i++) if (z[i]) p = p ^ (AW'(x) << i);
        if (m) begin
            for (int k = AW - 1; k >= W; k--) if (p[k]) p = p ^ (pf << (k - W));
        end
        return p;
    endfunction

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic m,
                         input logic [AW-1:0] e, output int acc_cyc);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        mode     = m;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        check("in_ready before accept", 32'(in_ready), 32'd1);
        exp_q.push_back(e);
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        mode     = ~m;
    endtask

    task automatic wait_result(input int exp_lat, input int acc_cyc);
        int guard;
        logic [AW-1:0] e;
        guard = 0;
        while (!out_valid && guard < 100) begin
            step();
            guard++;
        end
        check("latency", 32'(cyc - acc_cyc + 1), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: result %h with no expected entry", y);
        end else begin
            e = exp_q.pop_front();
            check("y", 32'(y), 32'(e));
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("in_ready after handshake", 32'(in_ready), 32'd1);
        check("out_valid after handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int acc_c;
        int prev_acc;
        int prev_lat;
        int gap;
        logic [W-1:0] x;
        logic [W-1:0] z;
        logic m;
        logic [AW-1:0] e;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 31'h55555555};
        vecs[1] = '{16'h8000, 16'h0002, 1'b0, 31'h00010000};
        vecs[2] = '{16'h8000, 16'h0002, 1'b1, 31'h0000100B};
        vecs[3] = '{16'h0003, 16'h0003, 1'b1, 31'h00000005};
        vecs[4] = '{16'h1234, 16'h0001, 1'b0, 31'h00001234};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 31'h00000000};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 31'h00000000};
        vecs[7] = '{16'h0002, 16'h8000, 1'b1, 31'h0000100B};

        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset y", 32'(y), 32'd0);
        #12 rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].vm, vecs[i].vy, acc_c);
            wait_result(vecs[i].vm ? N + R + 1 : N + 1, acc_c);
            handshake();
        end

        // Backpressure with an ignored in_valid pulse
        e = model(16'hABCD, 16'h1357, 1'b0);
        issue(16'hABCD, 16'h1357, 1'b0, e, acc_c);
        wait_result(N + 1, acc_c);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            a        = 16'h5A5A;
            b        = 16'hA5A5;
            mode     = 1'b1;
            step();
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
            check("hold y", 32'(y), 32'(e));
        end
        in_valid = 1'b0;
        handshake();

        // Reset two cycles after accept
        issue(16'h00FF, 16'h0F0F, 1'b1, model(16'h00FF, 16'h0F0F, 1'b1), acc_c);
        step();
        rst_n = 1'b0;
        #1;
        check("mid-op reset out_valid", 32'(out_valid), 32'd0);
        check("mid-op reset y", 32'(y), 32'd0);
        check("mid-op reset in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        #3 rst_n = 1'b1;
        issue(16'hC3A5, 16'h7E81, 1'b1, model(16'hC3A5, 16'h7E81, 1'b1), acc_c);
        wait_result(N + R + 1, acc_c);
        handshake();

        // Random stream with out_ready gaps
        prev_acc = 0;
        prev_lat = 0;
        for (int i = 0; i < 8; i++) begin
            x = W'($urandom);
            z = W'($urandom);
            m = 1'($urandom_range(0, 1));
            issue(x, z, m, model(x, z, m), acc_c);
            if (i > 0) check("issue interval", 32'(acc_c - prev_acc), 32'(prev_lat + 1 + gap));
            wait_result(m ? N + R + 1 : N + 1, acc_c);
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            handshake();
            prev_acc = acc_c;
            prev_lat = m ? N + R + 1 : N + 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
